dm_line_responder: RTL and testbench
====================================

// Module: dm_line_responder
// PURPOSE
//  Data-memory responder at the memory end of the dcache<->DM interface.
//  Serves write-through single-word stores and 16-word line fills out of a private word array.
//  Applies a programmable access latency before servicing each request.
//  Sits between the dcache miss/store path and the backing data memory.
// PARAMETERS
//  ADDR_W      32     byte address width (matches `DmAddr)
//  WORD_W      32     data word width (matches `RegBus)
//  LINE_WORDS  16     words per cache line; line width = LINE_WORDS*WORD_W (`LineWidth)
//  DEPTH       16384  array depth in words, power of two
//  ACC_LAT     4      wait cycles before service, >=0
// PORTS
//  clk           in   1                  clock, all logic rising-edge
//  rst           in   1                  synchronous, active-high reset
//  dm_read_i     in   1                  line-fill request, held until dm_ready_o
//  dm_write_i    in   1                  word-store request, held until dm_ready_o
//  dm_address_i  in   ADDR_W             byte address
//  dm_data_i     in   WORD_W             store data
//  dm_line_o     out  LINE_WORDS*WORD_W  fill data, word k at bits [k*WORD_W +: WORD_W]
//  dm_ready_o    out  1                  one-cycle completion pulse
//  dm_busy_o     out  1                  high while a request is in flight
// BEHAVIOUR
//  Reset and idle
//  - Reset values: dm_ready_o=0, dm_busy_o=0, dm_line_o=0, FSM=IDLE, counters=0.
//  - The array is never reset.
//  Request acceptance
//  - FSM states: IDLE, WAIT, WRITE, FILL, DONE.
//  - Requests are sampled only in IDLE. Cycle 0 is the IDLE cycle with a request high.
//  - In cycle 0, latch the address, store data, and the rd/wr flags.
//  - dm_busy_o is high in cycles 1 through DONE.
//  Latency and service
//  - WAIT lasts ACC_LAT cycles; with ACC_LAT=0, WAIT is skipped.
//  - WRITE: one cycle. Store word index addr[log2(DEPTH)+1:2] (byte lanes ignored).
//  - FILL: issue line base addr with the low log2(LINE_WORDS)+2 bits zeroed.
//  - FILL words 0..LINE_WORDS-1 one per cycle to the 1-cycle synchronous-read array.
//  - Capture each word into dm_line_o slot k one cycle after issue.
//  - One extra drain cycle follows, so FILL lasts LINE_WORDS+1 cycles.
//  Completion
//  - DONE: dm_ready_o=1 for exactly this cycle; then IDLE.
//  - A request still high in the cycle after DONE is treated as new (cache drops it on seeing ready).
//  - Write completion: dm_ready_o in cycle ACC_LAT+2.
//  - Read completion: dm_ready_o in cycle ACC_LAT+LINE_WORDS+2.
//  - dm_line_o holds its value from the DONE cycle until the next fill begins capturing.
//  Simultaneous read and write
//  - Order is WAIT, WRITE, FILL, DONE. No second WAIT.
//  - The returned line contains the just-stored word.
//  - A single dm_ready_o pulse in cycle ACC_LAT+LINE_WORDS+3.
//  Boundary conditions
//  - Address bits above log2(DEPTH)+1 are ignored, so the array wraps modulo DEPTH.
//  - The fill word counter wraps within the line only; a fill never crosses a line.
//  - Input changes while busy are ignored; latched values are used.
//  - Reset mid-operation aborts immediately: no ready pulse, a partial line is discarded, outputs are reset.
//  - An in-flight array write already issued at the reset edge may complete; this is don't-care for verification.
// STRUCTURE
//  Shared package dm_pkg:
//  - dm_state_e enum (IDLE, WAIT, WRITE, FILL, DONE)
//  - WORD_W/LINE_WORDS/ADDR_W constants
//  - line_t typedef (logic [LINE_WORDS*WORD_W-1:0])
//  Sub-module dm_word_ram:
//  - single-port, synchronous read, 1-cycle latency
//  - inputs we, addr, wdata; output rdata
//  - inferred array, no reset
//  Top-level contents: FSM, latency counter, fill counter, line assembly register.
// TESTING (ACC_LAT=4, LINE_WORDS=16)
//  1. Store: write 0x1000 data 0xDEADBEEF.
//     -> busy cycles 1-6, ready only in cycle 6.
//     -> a later fill of 0x1000 returns word0 = 0xDEADBEEF.
//  2. Fill: preload words base+k = k*0x11 and read 0x2024.
//     -> base 0x2000, ready in cycle 22, dm_line_o word k = k*0x11.
//  3. Read and write both high, address 0x3008, data 0xA5A5A5A5.
//     -> single ready in cycle 23, line word 2 = 0xA5A5A5A5.
//  4. Wrap: write DEPTH*4+0x40 with data 0x5.
//     -> fill of 0x40 returns word0 = 0x5.
//  5. Back-to-back: request held one cycle past ready.
//     -> the cycle after DONE accepts it as new, busy rises next cycle, ready again 22 cycles later.
//  6. rst asserted in FILL cycle 10.
//     -> next cycle ready=0, busy=0, line=0.
//     -> IDLE accepts a fresh request normally.

Source files
------------

// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared types and constants for the data-memory line responder
package dm_pkg;

    localparam int ADDR_W     = 32;
    localparam int WORD_W     = 32;
    localparam int LINE_WORDS = 16;

    typedef logic [LINE_WORDS*WORD_W-1:0] line_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        WRITE,
        FILL,
        DONE
    } dm_state_e;

endpackage

// File: rtl/dm_word_ram.sv
// rtl/dm_word_ram.sv - single-port word array with one-cycle synchronous read
module dm_word_ram #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 16384,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    // Contents are never reset; they persist across responder resets.
    logic [WORD_W-1:0] mem [DEPTH];

    // Write on we; read data reflects the addressed word one cycle later.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dm_line_responder.sv
// rtl/dm_line_responder.sv - memory-side responder for word stores and line fills
module dm_line_responder #(
    parameter int ADDR_W     = dm_pkg::ADDR_W,
    parameter int WORD_W     = dm_pkg::WORD_W,
    parameter int LINE_WORDS = dm_pkg::LINE_WORDS,
    parameter int DEPTH      = 16384,
    parameter int ACC_LAT    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         dm_read_i,
    input  logic                         dm_write_i,
    input  logic [ADDR_W-1:0]            dm_address_i,
    input  logic [WORD_W-1:0]            dm_data_i,
    output logic [LINE_WORDS*WORD_W-1:0] dm_line_o,
    output logic                         dm_ready_o,
    output logic                         dm_busy_o
);

    import dm_pkg::*;

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int LOG_LW = $clog2(LINE_WORDS);
    localparam int LAT_W  = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;

    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'((ACC_LAT > 0) ? ACC_LAT - 1 : 0);
    localparam logic [LOG_LW:0]   FILL_LAST = (LOG_LW+1)'(LINE_WORDS);

    dm_state_e          state;
    logic               rd_q;
    logic               wr_q;
    logic [IDX_W-1:0]   idx_q;
    logic [WORD_W-1:0]  data_q;
    logic [LAT_W-1:0]   lat_cnt;
    logic [LOG_LW:0]    fill_cnt;
    logic [LOG_LW-1:0]  slot;

    logic               ram_we;
    logic [IDX_W-1:0]   ram_addr;
    logic [WORD_W-1:0]  ram_rdata;

    // Byte lanes and address bits above the array are deliberately dropped.
    logic unused_addr;
    assign unused_addr = ^{dm_address_i[ADDR_W-1:IDX_W+2], dm_address_i[1:0]};

    // Word arriving from the array this cycle belongs to the previous issue.
    assign slot = LOG_LW'(fill_cnt - 1'b1);

    // Array port: store the latched word in WRITE, otherwise walk the line.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = {idx_q[IDX_W-1:LOG_LW], fill_cnt[LOG_LW-1:0]};
        if (state == WRITE) begin
            ram_we   = 1'b1;
            ram_addr = idx_q;
        end
    end

    dm_word_ram #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (data_q),
        .rdata (ram_rdata)
    );

    // Request sequencing, latency and fill counters, and line assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            idx_q      <= '0;
            data_q     <= '0;
            lat_cnt    <= '0;
            fill_cnt   <= '0;
            dm_line_o  <= '0;
            dm_ready_o <= 1'b0;
            dm_busy_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dm_read_i || dm_write_i) begin
                        rd_q      <= dm_read_i;
                        wr_q      <= dm_write_i;
                        idx_q     <= dm_address_i[IDX_W+1:2];
                        data_q    <= dm_data_i;
                        lat_cnt   <= '0;
                        fill_cnt  <= '0;
                        dm_busy_o <= 1'b1;
                        if (ACC_LAT > 0) begin
                            state <= WAIT;
                        end else if (dm_write_i) begin
                            state <= WRITE;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                WAIT: begin
                    if (lat_cnt == LAT_LAST) begin
                        state <= wr_q ? WRITE : FILL;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                WRITE: begin
                    // A combined request continues straight into the fill.
                    if (rd_q) begin
                        state <= FILL;
                    end else begin
                        state      <= DONE;
                        dm_ready_o <= 1'b1;
                    end
                end
                FILL: begin
                    fill_cnt <= fill_cnt + 1'b1;
                    if (fill_cnt != '0) begin
                        dm_line_o[int'(slot)*WORD_W +: WORD_W] <= ram_rdata;
                    end
                    if (fill_cnt == FILL_LAST) begin
                        state      <= DONE;
                        dm_ready_o <= 1'b1;
                    end
                end
                DONE: begin
                    dm_ready_o <= 1'b0;
                    dm_busy_o  <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    dm_ready_o <= 1'b0;
                    dm_busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_line_responder.sv
// tb/tb_dm_line_responder.sv - self-checking bench for dm_line_responder
module tb_dm_line_responder;

    localparam int DEPTH   = 16384;
    localparam int ACC_LAT = 4;
    localparam int LW      = 16;
    localparam int WR_LAT  = ACC_LAT + 2;
    localparam int RD_LAT  = ACC_LAT + LW + 2;
    localparam int RW_LAT  = ACC_LAT + LW + 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            dm_read;
    logic            dm_write;
    logic [31:0]     dm_address;
    logic [31:0]     dm_data;
    logic [LW*32-1:0] dm_line;
    logic            dm_ready;
    logic            dm_busy;

    int checks = 0;
    int errors = 0;

    bit [31:0] mem [int];

    dm_line_responder #(
        .ADDR_W     (32),
        .WORD_W     (32),
        .LINE_WORDS (LW),
        .DEPTH      (DEPTH),
        .ACC_LAT    (ACC_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .dm_read_i    (dm_read),
        .dm_write_i   (dm_write),
        .dm_address_i (dm_address),
        .dm_data_i    (dm_data),
        .dm_line_o    (dm_line),
        .dm_ready_o   (dm_ready),
        .dm_busy_o    (dm_busy)
    );

    always #5 clk = ~clk;

    function automatic int word_idx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic int line_base(input logic [31:0] a);
        return word_idx(a) - (word_idx(a) % LW);
    endfunction

    // Drives one request starting in the current (idle) cycle and watches it complete.
    task automatic run_req(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input bit scramble,
                           output int rdy_cyc, output int rdy_cnt, output int busy_bad,
                           output logic busy_after, output logic [LW*32-1:0] line);
        dm_read = rd; dm_write = wr; dm_address = a; dm_data = d;
        rdy_cyc = -1; rdy_cnt = 0; busy_bad = 0; busy_after = 1'bx; line = '0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); @(negedge clk);
            if (rdy_cyc < 0 && dm_busy !== 1'b1) busy_bad++;
            if (rdy_cyc > 0 && n == rdy_cyc + 1) busy_after = dm_busy;
            if (dm_ready === 1'b1) begin
                rdy_cnt++;
                if (rdy_cyc < 0) begin
                    rdy_cyc = n;
                    line = dm_line;
                end
            end
            if (rdy_cyc > 0) begin
                dm_read = 1'b0; dm_write = 1'b0;
            end else if (scramble) begin
                dm_address = $urandom; dm_data = $urandom;
            end
            if (rdy_cyc > 0 && n >= rdy_cyc + 2) break;
        end
        dm_read = 1'b0; dm_write = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; dm_read = 0; dm_write = 0; dm_address = 0; dm_data = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (dm_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", dm_ready); end
        checks++; if (dm_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", dm_busy); end
        checks++; if (dm_line !== '0) begin errors++; $display("FAIL reset_line got %h want 0", dm_line); end
    endtask

    task automatic test_store;
        int rc, cnt, bb; logic ba; logic [LW*32-1:0] ln;
        run_req(0, 1, 32'h1000, 32'hDEADBEEF, 1, rc, cnt, bb, ba, ln);
        mem[word_idx(32'h1000)] = 32'hDEADBEEF;
        checks++; if (rc != WR_LAT) begin errors++; $display("FAIL store_ready_cycle got %0d want %0d", rc, WR_LAT); end
        checks++; if (cnt != 1) begin errors++; $display("FAIL store_ready_count got %0d want 1", cnt); end
        checks++; if (bb != 0) begin errors++; $display("FAIL store_busy got %0d low cycles want 0", bb); end
        checks++; if (ba !== 1'b0) begin errors++; $display("FAIL store_busy_after got %b want 0", ba); end
        run_req(1, 0, 32'h1000, 32'h0, 1, rc, cnt, bb, ba, ln);
        checks++; if (rc != RD_LAT) begin errors++; $display("FAIL store_fill_cycle got %0d want %0d", rc, RD_LAT); end
        checks++; if (ln[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL store_readback got %h want deadbeef", ln[31:0]); end
    endtask

    task automatic test_fill;
        int rc, cnt, bb; logic ba; logic [LW*32-1:0] ln;
        for (int k = 0; k < LW; k++) begin
            run_req(0, 1, 32'h2000 + 32'(4*k), 32'(k * 32'h11), 0, rc, cnt, bb, ba, ln);
            mem[word_idx(32'h2000 + 32'(4*k))] = 32'(k * 32'h11);
        end
        run_req(1, 0, 32'h2024, 32'h0, 1, rc, cnt, bb, ba, ln);
        checks++; if (rc != RD_LAT) begin errors++; $display("FAIL fill_ready_cycle got %0d want %0d", rc, RD_LAT); end
        checks++; if (cnt != 1) begin errors++; $display("FAIL fill_ready_count got %0d want 1", cnt); end
        checks++; if (bb != 0) begin errors++; $display("FAIL fill_busy got %0d low cycles want 0", bb); end
        for (int k = 0; k < LW; k++) begin
            checks++;
            if (ln[k*32 +: 32] !== 32'(k * 32'h11)) begin
                errors++; $display("FAIL fill_word%0d got %h want %h", k, ln[k*32 +: 32], 32'(k * 32'h11));
            end
        end
    endtask

    task automatic test_rw;
        int rc, cnt, bb; logic ba; logic [LW*32-1:0] ln;
        run_req(1, 1, 32'h3008, 32'hA5A5A5A5, 1, rc, cnt, bb, ba, ln);
        mem[word_idx(32'h3008)] = 32'hA5A5A5A5;
        checks++; if (rc != RW_LAT) begin errors++; $display("FAIL rw_ready_cycle got %0d want %0d", rc, RW_LAT); end
        checks++; if (cnt != 1) begin errors++; $display("FAIL rw_ready_count got %0d want 1", cnt); end
        checks++; if (ln[2*32 +: 32] !== 32'hA5A5A5A5) begin errors++; $display("FAIL rw_word2 got %h want a5a5a5a5", ln[2*32 +: 32]); end
    endtask

    task automatic test_wrap;
        int rc, cnt, bb; logic ba; logic [LW*32-1:0] ln;
        logic [31:0] a;
        a = 32'(DEPTH * 4) + 32'h40;
        run_req(0, 1, a, 32'h5, 0, rc, cnt, bb, ba, ln);
        mem[word_idx(a)] = 32'h5;
        run_req(1, 0, 32'h40, 32'h0, 0, rc, cnt, bb, ba, ln);
        checks++; if (ln[31:0] !== 32'h5) begin errors++; $display("FAIL wrap_word0 got %h want 5", ln[31:0]); end
    endtask

    task automatic test_back_to_back;
        int rc, rc2;
        dm_read = 1'b1; dm_write = 1'b0; dm_address = 32'h2024; dm_data = 0;
        rc = -1;
        for (int n = 1; n <= 40 && rc < 0; n++) begin
            @(posedge clk); @(negedge clk);
            if (dm_ready === 1'b1) rc = n;
        end
        checks++; if (rc != RD_LAT) begin errors++; $display("FAIL b2b_first_ready got %0d want %0d", rc, RD_LAT); end
        // Request stays high through the idle cycle that follows DONE.
        @(posedge clk); @(negedge clk);
        checks++; if (dm_busy !== 1'b0 || dm_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_gap got busy=%b ready=%b want 0 0", dm_busy, dm_ready); end
        rc2 = -1;
        for (int n = 1; n <= 40 && rc2 < 0; n++) begin
            @(posedge clk); @(negedge clk);
            if (n == 1) begin
                checks++; if (dm_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_rise got %b want 1", dm_busy); end
            end
            if (dm_ready === 1'b1) rc2 = n;
        end
        dm_read = 1'b0;
        checks++; if (rc2 != RD_LAT) begin errors++; $display("FAIL b2b_second_ready got %0d want %0d", rc2, RD_LAT); end
        checks++; if (dm_line[5*32 +: 32] !== mem[line_base(32'h2024) + 5]) begin
            errors++; $display("FAIL b2b_word5 got %h want %h", dm_line[5*32 +: 32], mem[line_base(32'h2024) + 5]); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int rc, cnt, bb, pulses; logic ba; logic [LW*32-1:0] ln;
        dm_read = 1'b1; dm_address = 32'h2000;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0; dm_read = 1'b0;
        checks++; if (dm_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready got %b want 0", dm_ready); end
        checks++; if (dm_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", dm_busy); end
        checks++; if (dm_line !== '0) begin errors++; $display("FAIL rstmid_line got %h want 0", dm_line); end
        pulses = 0;
        for (int n = 0; n < 25; n++) begin
            @(posedge clk); @(negedge clk);
            if (dm_ready !== 1'b0 || dm_busy !== 1'b0) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL rstmid_quiet got %0d active cycles want 0", pulses); end
        run_req(1, 0, 32'h2000, 32'h0, 0, rc, cnt, bb, ba, ln);
        checks++; if (rc != RD_LAT) begin errors++; $display("FAIL rstmid_refill_cycle got %0d want %0d", rc, RD_LAT); end
        checks++; if (ln[7*32 +: 32] !== mem[line_base(32'h2000) + 7]) begin
            errors++; $display("FAIL rstmid_word7 got %h want %h", ln[7*32 +: 32], mem[line_base(32'h2000) + 7]); end
    endtask

    task automatic test_random;
        int rc, cnt, bb, kind, lat, base; logic ba; logic [LW*32-1:0] ln;
        logic [31:0] a, d;
        for (int t = 0; t < 24; t++) begin
            kind = $urandom_range(0, 2);
            a = {16'($urandom), 14'(32'h100 + $urandom_range(0, 63)), 2'($urandom)};
            d = $urandom;
            run_req(kind != 0, kind != 1, a, d, 1, rc, cnt, bb, ba, ln);
            if (kind != 1) mem[word_idx(a)] = d;
            lat = (kind == 0) ? WR_LAT : (kind == 1) ? RD_LAT : RW_LAT;
            checks++; if (rc != lat || cnt != 1 || bb != 0) begin
                errors++; $display("FAIL rand%0d_timing got cyc=%0d cnt=%0d busylow=%0d want cyc=%0d cnt=1 busylow=0", t, rc, cnt, bb, lat); end
            if (kind != 0) begin
                base = line_base(a);
                for (int k = 0; k < LW; k++) begin
                    if (mem.exists(base + k)) begin
                        checks++;
                        if (ln[k*32 +: 32] !== mem[base + k]) begin
                            errors++; $display("FAIL rand%0d_word%0d got %h want %h", t, k, ln[k*32 +: 32], mem[base + k]);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_fill();
        test_rw();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
